// File: rtl/morse_symbol_assembler.sv
// morse_symbol_assembler: dot/dash symbol assembler with registered symbol FIFO; define MORSE_ASM_OVERFLOW_EN for overflow error flag
module morse_symbol_assembler #(
  parameter int MAX_LEN = 5,
  parameter int FIFO_DEPTH = 4,
  localparam int LW = $clog2(MAX_LEN + 1),
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dot,
  input  logic               dash,
  input  logic               lg,
  input  logic               wg,
  output logic [MAX_LEN-1:0] cur_pattern,
  output logic [LW-1:0]      cur_len,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MAX_LEN-1:0] out_pattern,
  output logic [LW-1:0]      out_len,
  output logic               out_word,
  output logic               out_err,
  output logic [CW-1:0]      level,
  output logic               dropped
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic               elem, full, app, close, pop, push;
  logic [MAX_LEN-1:0] nxt_pat;
  logic [LW-1:0]      nxt_len;
  logic [MAX_LEN-1:0] mem_pat [FIFO_DEPTH];
  logic [LW-1:0]      mem_len [FIFO_DEPTH];
  logic               mem_word [FIFO_DEPTH];
  logic [AW-1:0]      wp, rp;
  logic [CW-1:0]      cnt;
  always_comb begin
    elem = dot ^ dash;
    full = cur_len == LW'(MAX_LEN);
    app = elem & ~full;
    nxt_pat = app ? cur_pattern | (MAX_LEN'(dash) << cur_len) : cur_pattern;
    nxt_len = cur_len + LW'(app);
    close = (lg | wg) & ((cur_len != '0) | elem);
    pop = out_valid & out_ready;
    push = close & ((cnt != CW'(FIFO_DEPTH)) | pop);
  end
  assign out_valid = cnt != '0;
  assign level = cnt;
  assign out_pattern = out_valid ? mem_pat[rp] : '0;
  assign out_len = out_valid ? mem_len[rp] : '0;
  assign out_word = out_valid & mem_word[rp];
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_pattern <= '0;
      cur_len <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      dropped <= 1'b0;
    end else begin
      cur_pattern <= close ? '0 : nxt_pat;
      cur_len <= close ? '0 : nxt_len;
      if (push) begin
        mem_pat[wp] <= nxt_pat;
        mem_len[wp] <= nxt_len;
        mem_word[wp] <= wg;
        wp <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
      if (close & ~push) dropped <= 1'b1;
    end
  end
`ifdef MORSE_ASM_OVERFLOW_EN
  logic err, nxt_err;
  logic mem_err [FIFO_DEPTH];
  assign nxt_err = err | (elem & full);
  assign out_err = out_valid & mem_err[rp];
  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else begin
      err <= close ? 1'b0 : nxt_err;
      if (push) mem_err[wp] <= nxt_err;
    end
  end
`else
  assign out_err = 1'b0;
`endif
endmodule

// File: tb/tb_morse_symbol_assembler.sv
// tb_morse_symbol_assembler: randomized and directed check of morse_symbol_assembler against a queue-based reference model
module tb_morse_symbol_assembler;
  localparam int ML = 5;
  localparam int FD = 4;
  logic clk = 0, reset, dot, dash, lg, wg, out_ready;
  logic [ML-1:0] cur_pattern, out_pattern;
  logic [2:0] cur_len, out_len, level;
  logic out_valid, out_word, out_err, dropped;
  typedef struct { int pat; int len; bit word; bit err; } ent_t;
  bit sym_q[$];
  ent_t fifo_q[$];
  bit err_m, drop_m;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  morse_symbol_assembler #(.MAX_LEN(ML), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .dot(dot), .dash(dash), .lg(lg), .wg(wg),
    .cur_pattern(cur_pattern), .cur_len(cur_len), .out_valid(out_valid),
    .out_ready(out_ready), .out_pattern(out_pattern), .out_len(out_len),
    .out_word(out_word), .out_err(out_err), .level(level), .dropped(dropped)
  );
  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int pat_of(input int n);
    int p = 0;
    for (int i = 0; i < n; i++) p += int'(sym_q[i]) * (1 << i);
    return p;
  endfunction
  task automatic model_step(input bit d, input bit a, input bit l, input bit w, input bit r, input bit rs);
    bit do_pop;
    ent_t e;
    if (rs) begin
      sym_q.delete();
      fifo_q.delete();
      err_m = 0;
      drop_m = 0;
      return;
    end
    do_pop = fifo_q.size() > 0 && r;
    if (d != a) begin
      if (sym_q.size() < ML) sym_q.push_back(a);
`ifdef MORSE_ASM_OVERFLOW_EN
      else err_m = 1;
`endif
    end
    if (do_pop) void'(fifo_q.pop_front());
    if ((l || w) && sym_q.size() > 0) begin
      e.pat = pat_of(sym_q.size());
      e.len = sym_q.size();
      e.word = w;
      e.err = err_m;
      if (fifo_q.size() < FD) fifo_q.push_back(e);
      else drop_m = 1;
      sym_q.delete();
      err_m = 0;
    end
  endtask
  task automatic compare_all();
    bit v = fifo_q.size() > 0;
    chk("cur_pattern", cur_pattern, pat_of(sym_q.size()));
    chk("cur_len", cur_len, sym_q.size());
    chk("out_valid", out_valid, v);
    chk("out_pattern", out_pattern, v ? fifo_q[0].pat : 0);
    chk("out_len", out_len, v ? fifo_q[0].len : 0);
    chk("out_word", out_word, v ? fifo_q[0].word : 0);
    chk("out_err", out_err, v ? fifo_q[0].err : 0);
    chk("level", level, fifo_q.size());
    chk("dropped", dropped, drop_m);
  endtask
  task automatic cycle(input bit d, input bit a, input bit l, input bit w, input bit r, input bit rs);
    dot = d; dash = a; lg = l; wg = w; out_ready = r; reset = rs;
    model_step(d, a, l, w, r, rs);
    @(negedge clk);
    compare_all();
  endtask
  task automatic sym(input int n, input bit a, input bit w, input bit r);
    for (int i = 0; i < n; i++) cycle(!a, a, 0, 0, r, 0);
    cycle(0, 0, !w, w, r, 0);
  endtask
  initial begin
    err_m = 0;
    drop_m = 0;
    cycle(0, 0, 0, 0, 0, 1);
    chk("rst_level", level, 0);
    chk("rst_valid", out_valid, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    chk("e39_pat", out_pattern, 5'b00010);
    chk("e39_len", out_len, 3);
    chk("e39_word", out_word, 0);
    chk("e39_cur_len", cur_len, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    chk("e40_pat", out_pattern, 5'b00011);
    chk("e40_len", out_len, 3);
    chk("e40_word", out_word, 1);
    cycle(0, 0, 0, 0, 1, 0);
    chk("both_ignored_pre", cur_len, 0);
    cycle(1, 1, 0, 0, 0, 0);
    chk("both_ignored", cur_len, 0);
    cycle(0, 0, 1, 0, 0, 0);
    chk("empty_gap", level, 0);
    sym(6, 1, 0, 0);
    chk("e41_pat", out_pattern, 5'b11111);
    chk("e41_len", out_len, 5);
`ifdef MORSE_ASM_OVERFLOW_EN
    chk("e41_err", out_err, 1);
`else
    chk("e41_err", out_err, 0);
`endif
    cycle(0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 5; k++) sym(k, 0, 0, 0);
    chk("e42_level", level, 4);
    chk("e42_dropped", dropped, 1);
    for (int k = 1; k <= 4; k++) begin
      chk("e42_order", out_len, k);
      cycle(0, 0, 0, 0, 1, 0);
    end
    chk("e42_empty", out_valid, 0);
    cycle(0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 4; k++) sym(k, 0, 0, 0);
    cycle(0, 1, 1, 0, 1, 0);
    chk("e43_level", level, 4);
    chk("e43_dropped", dropped, 0);
    for (int k = 2; k <= 4; k++) begin
      chk("e43_order", out_len, k);
      cycle(0, 0, 0, 0, 1, 0);
    end
    chk("e43_last_pat", out_pattern, 1);
    chk("e43_last_len", out_len, 1);
    cycle(0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 3; k++) sym(1, 1, 1, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    chk("e44_pre_len", cur_len, 2);
    chk("e44_pre_level", level, 3);
    cycle(1, 0, 1, 0, 1, 1);
    chk("e44_cur_len", cur_len, 0);
    chk("e44_level", level, 0);
    chk("e44_valid", out_valid, 0);
    cycle(0, 0, 1, 0, 0, 0);
    chk("e44_no_entry", level, 0);
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3, $urandom_range(0, 19) < 3,
            $urandom_range(0, 19) < 2, $urandom_range(0, 9) < 4, $urandom_range(0, 99) < 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
